// File: rtl/sqrt_job_sequencer.sv
// Square-root job sequencer: accepts operands on a valid/ready stream, presents
// each one to the root datapath, pulses Start to the controller, waits for Done
// (guarded by a watchdog) and returns the captured root on an output stream.
// One pending slot lets the next operand queue while a result is unconsumed.
module sqrt_job_sequencer #(
   parameter int WIDTH     = 16,
   parameter int RES_WIDTH = 8,
   parameter int TIMEOUT   = 64
) (
   input  logic                 clk,
   input  logic                 CLR,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 Start,
   input  logic                 Done,
   output logic [WIDTH-1:0]     dp_operand,
   input  logic [RES_WIDTH-1:0] dp_result,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [RES_WIDTH-1:0] out_data,
   output logic                 out_err,
   output logic                 busy
);

   // Watchdog only needs to reach TIMEOUT-1 before the abort fires.
   localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t            state_reg;
   logic              pend_valid_reg;
   logic [WIDTH-1:0]  pend_data_reg;
   logic [WD_W-1:0]   wd_cnt_reg;
   logic              in_fire;
   logic              out_fire;

   // Operands are taken when idle, or while a result waits and the slot is free.
   assign in_ready = (state_reg == S_IDLE) ||
                     ((state_reg == S_OUT) && !pend_valid_reg);
   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // Sequencer FSM with all outputs registered; Done matters only in S_WAIT.
   always_ff @(posedge clk or negedge CLR) begin
      if (!CLR) begin
         state_reg      <= S_IDLE;
         Start          <= 1'b0;
         out_valid      <= 1'b0;
         out_err        <= 1'b0;
         out_data       <= '0;
         dp_operand     <= '0;
         pend_valid_reg <= 1'b0;
         pend_data_reg  <= '0;
         wd_cnt_reg     <= '0;
         busy           <= 1'b0;
      end else begin
         Start <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (in_fire) begin
                  dp_operand <= in_data;
                  Start      <= 1'b1;
                  busy       <= 1'b1;
                  state_reg  <= S_START;
               end
            end

            S_START: begin
               wd_cnt_reg <= '0;
               state_reg  <= S_WAIT;
            end

            S_WAIT: begin
               wd_cnt_reg <= wd_cnt_reg + 1'b1;
               if (Done) begin
                  out_data  <= dp_result;
                  out_err   <= 1'b0;
                  out_valid <= 1'b1;
                  state_reg <= S_OUT;
               end else if (wd_cnt_reg == WD_LAST) begin
                  out_data  <= '0;
                  out_err   <= 1'b1;
                  out_valid <= 1'b1;
                  state_reg <= S_OUT;
               end
            end

            S_OUT: begin
               if (out_fire) begin
                  out_valid <= 1'b0;
                  if (pend_valid_reg) begin
                     // Back-to-back job from the pending slot.
                     dp_operand     <= pend_data_reg;
                     pend_valid_reg <= 1'b0;
                     Start          <= 1'b1;
                     state_reg      <= S_START;
                  end else if (in_fire) begin
                     // Operand arriving with the handshake bypasses the slot.
                     dp_operand <= in_data;
                     Start      <= 1'b1;
                     state_reg  <= S_START;
                  end else begin
                     busy      <= 1'b0;
                     state_reg <= S_IDLE;
                  end
               end else if (in_fire) begin
                  pend_data_reg  <= in_data;
                  pend_valid_reg <= 1'b1;
               end
            end

            default: begin
               busy      <= 1'b0;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sqrt_job_sequencer.sv
// Directed bench for sqrt_job_sequencer. Instance A uses TIMEOUT=64 for the
// normal, queueing, spurious-Done and reset scenarios; instance B uses
// TIMEOUT=8 for the watchdog scenarios. Done/dp_result are driven directly.
module tb_sqrt_job_sequencer;

   logic clk = 1'b0;
   logic CLR = 1'b0;

   logic        a_in_valid = 1'b0, a_in_ready, a_Start, a_Done = 1'b0;
   logic        a_out_valid, a_out_ready = 1'b0, a_out_err, a_busy;
   logic [15:0] a_in_data = '0, a_dp_operand;
   logic [7:0]  a_dp_result = '0, a_out_data;

   logic        b_in_valid = 1'b0, b_in_ready, b_Start, b_Done = 1'b0;
   logic        b_out_valid, b_out_ready = 1'b0, b_out_err, b_busy;
   logic [15:0] b_in_data = '0, b_dp_operand;
   logic [7:0]  b_dp_result = '0, b_out_data;

   int n_pass  = 0;
   int n_total = 0;

   sqrt_job_sequencer #(.WIDTH(16), .RES_WIDTH(8), .TIMEOUT(64)) u_dut_a (
      .clk(clk), .CLR(CLR),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .Start(a_Start), .Done(a_Done), .dp_operand(a_dp_operand), .dp_result(a_dp_result),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_err(a_out_err), .busy(a_busy)
   );

   sqrt_job_sequencer #(.WIDTH(16), .RES_WIDTH(8), .TIMEOUT(8)) u_dut_b (
      .clk(clk), .CLR(CLR),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .Start(b_Start), .Done(b_Done), .dp_operand(b_dp_operand), .dp_result(b_dp_result),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_err(b_out_err), .busy(b_busy)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input string name, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s.%s observed=%0d expected=%0d", tag, name, obs, exp);
   endtask

   // One job on A: Done raised dc cycles after WAIT entry; result held one cycle before handshake.
   task automatic a_run(input string tag, input logic [15:0] data, input int dc,
                        input logic [7:0] res);
      int k_seen;
      k_seen = -1;
      a_in_valid = 1'b1; a_in_data = data;
      step;
      a_in_valid = 1'b0;
      chk(tag, "start", 32'(a_Start), 1);
      chk(tag, "operand", 32'(a_dp_operand), 32'(data));
      chk(tag, "rdy_start", 32'(a_in_ready), 0);
      step;
      chk(tag, "start_1cyc", 32'(a_Start), 0);
      for (int k = 0; k < 80; k++) begin
         if (k == dc) begin a_Done = 1'b1; a_dp_result = res; end
         step;
         a_Done = 1'b0;
         if (a_out_valid) begin k_seen = k; break; end
      end
      chk(tag, "latency", k_seen, dc);
      chk(tag, "data", 32'(a_out_data), 32'(res));
      chk(tag, "err", 32'(a_out_err), 0);
      step;
      chk(tag, "hold_valid", 32'(a_out_valid), 1);
      chk(tag, "hold_data", 32'(a_out_data), 32'(res));
      a_out_ready = 1'b1;
      step;
      a_out_ready = 1'b0;
      chk(tag, "idle_busy", 32'(a_busy), 0);
      chk(tag, "idle_rdy", 32'(a_in_ready), 1);
   endtask

   // One job on B (TIMEOUT=8); dc<0 means Done never comes.
   task automatic b_run(input string tag, input logic [15:0] data, input int dc,
                        input logic [7:0] res, input int exp_err, input int exp_data,
                        input int exp_k);
      int k_seen;
      k_seen = -1;
      b_in_valid = 1'b1; b_in_data = data;
      step;
      b_in_valid = 1'b0;
      chk(tag, "start", 32'(b_Start), 1);
      step;
      for (int k = 0; k < 20; k++) begin
         if (k == dc) begin b_Done = 1'b1; b_dp_result = res; end
         step;
         b_Done = 1'b0;
         if (b_out_valid) begin k_seen = k; break; end
      end
      chk(tag, "latency", k_seen, exp_k);
      chk(tag, "err", 32'(b_out_err), exp_err);
      chk(tag, "data", 32'(b_out_data), exp_data);
      b_out_ready = 1'b1;
      step;
      b_out_ready = 1'b0;
      chk(tag, "idle_busy", 32'(b_busy), 0);
   endtask

   // Linear sequence of directed scenarios.
   initial begin
      step; step;
      chk("rst", "a_rdy", 32'(a_in_ready), 1);
      chk("rst", "a_start", 32'(a_Start), 0);
      chk("rst", "a_valid", 32'(a_out_valid), 0);
      chk("rst", "a_busy", 32'(a_busy), 0);
      chk("rst", "a_data", 32'(a_out_data), 0);
      chk("rst", "a_operand", 32'(a_dp_operand), 0);
      chk("rst", "b_rdy", 32'(b_in_ready), 1);
      chk("rst", "b_err", 32'(b_out_err), 0);
      #2 CLR = 1'b1;
      step;

      // Single job: 144 -> 12, Done ten cycles after Start.
      a_run("single", 16'd144, 9, 8'd12);

      // Backpressure and pending slot: 625 then 81.
      a_in_valid = 1'b1; a_in_data = 16'd625;
      step;
      chk("bp", "start625", 32'(a_Start), 1);
      a_in_data = 16'd81;
      chk("bp", "rdy_start", 32'(a_in_ready), 0);
      step;
      chk("bp", "rdy_wait", 32'(a_in_ready), 0);
      step; step;
      a_Done = 1'b1; a_dp_result = 8'd25;
      step;
      a_Done = 1'b0;
      chk("bp", "valid25", 32'(a_out_valid), 1);
      chk("bp", "data25", 32'(a_out_data), 25);
      chk("bp", "rdy_out", 32'(a_in_ready), 1);
      step;
      a_in_valid = 1'b0;
      chk("bp", "rdy_pend", 32'(a_in_ready), 0);
      chk("bp", "operand_held", 32'(a_dp_operand), 625);
      chk("bp", "data25_held", 32'(a_out_data), 25);
      step;
      chk("bp", "valid_held", 32'(a_out_valid), 1);
      a_out_ready = 1'b1;
      step;
      a_out_ready = 1'b0;
      chk("bp", "start81", 32'(a_Start), 1);
      chk("bp", "operand81", 32'(a_dp_operand), 81);
      chk("bp", "valid_drop", 32'(a_out_valid), 0);
      step;
      a_Done = 1'b1; a_dp_result = 8'd9;
      step;
      a_Done = 1'b0;
      chk("bp", "data9", 32'(a_out_data), 9);
      chk("bp", "valid9", 32'(a_out_valid), 1);
      a_out_ready = 1'b1;
      step;
      a_out_ready = 1'b0;
      chk("bp", "idle", 32'(a_busy), 0);

      // Spurious Done in IDLE, START and OUT.
      a_Done = 1'b1; a_dp_result = 8'd99;
      step; step; step;
      chk("spur", "idle_busy", 32'(a_busy), 0);
      chk("spur", "idle_valid", 32'(a_out_valid), 0);
      a_Done = 1'b0; a_in_valid = 1'b1; a_in_data = 16'd49;
      step;
      a_in_valid = 1'b0; a_Done = 1'b1; a_dp_result = 8'd77;
      step;
      a_Done = 1'b0;
      chk("spur", "start_done_ign", 32'(a_out_valid), 0);
      step; step;
      chk("spur", "wait_valid", 32'(a_out_valid), 0);
      a_Done = 1'b1; a_dp_result = 8'd7;
      step;
      a_dp_result = 8'd99;
      chk("spur", "data7", 32'(a_out_data), 7);
      step; step; step;
      chk("spur", "out_hold_data", 32'(a_out_data), 7);
      chk("spur", "out_hold_valid", 32'(a_out_valid), 1);
      chk("spur", "out_no_start", 32'(a_Start), 0);
      a_Done = 1'b0; a_out_ready = 1'b1;
      step;
      a_out_ready = 1'b0;
      chk("spur", "idle", 32'(a_busy), 0);

      // Async reset in WAIT.
      a_in_valid = 1'b1; a_in_data = 16'd100;
      step;
      a_in_valid = 1'b0;
      step; step;
      CLR = 1'b0;
      #1;
      chk("rst_wait", "rdy", 32'(a_in_ready), 1);
      chk("rst_wait", "busy", 32'(a_busy), 0);
      chk("rst_wait", "operand", 32'(a_dp_operand), 0);
      #2 CLR = 1'b1;
      step;

      // Async reset in OUT with a pending operand.
      a_in_valid = 1'b1; a_in_data = 16'd400;
      step;
      a_in_valid = 1'b0;
      step;
      a_Done = 1'b1; a_dp_result = 8'd20;
      step;
      a_Done = 1'b0; a_in_valid = 1'b1; a_in_data = 16'd900;
      step;
      a_in_valid = 1'b0;
      chk("rst_out", "pend_rdy", 32'(a_in_ready), 0);
      chk("rst_out", "data20", 32'(a_out_data), 20);
      CLR = 1'b0;
      #1;
      chk("rst_out", "rdy", 32'(a_in_ready), 1);
      chk("rst_out", "valid", 32'(a_out_valid), 0);
      chk("rst_out", "data", 32'(a_out_data), 0);
      chk("rst_out", "err", 32'(a_out_err), 0);
      chk("rst_out", "busy", 32'(a_busy), 0);
      chk("rst_out", "start", 32'(a_Start), 0);
      #2 CLR = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step;
         chk("rst_out", "no_pend_start", 32'(a_Start), 0);
      end
      a_run("fresh", 16'd16, 2, 8'd4);

      // Operand accept coincident with result handshake (slot empty).
      a_in_valid = 1'b1; a_in_data = 16'd1600;
      step;
      a_in_valid = 1'b0;
      step;
      a_Done = 1'b1; a_dp_result = 8'd40;
      step;
      a_Done = 1'b0;
      chk("bypass", "data40", 32'(a_out_data), 40);
      a_in_valid = 1'b1; a_in_data = 16'd36; a_out_ready = 1'b1;
      step;
      a_in_valid = 1'b0; a_out_ready = 1'b0;
      chk("bypass", "start36", 32'(a_Start), 1);
      chk("bypass", "operand36", 32'(a_dp_operand), 36);
      chk("bypass", "valid_drop", 32'(a_out_valid), 0);
      step;
      a_Done = 1'b1; a_dp_result = 8'd6;
      step;
      a_Done = 1'b0;
      chk("bypass", "data6", 32'(a_out_data), 6);
      a_out_ready = 1'b1;
      step;
      a_out_ready = 1'b0;
      chk("bypass", "idle", 32'(a_busy), 0);
      step;
      chk("bypass", "no_dup_start", 32'(a_Start), 0);

      // Watchdog scenarios on B (TIMEOUT=8).
      b_run("to1", 16'd50, -1, 8'd0, 1, 0, 7);
      b_run("nrm", 16'd64, 3, 8'd8, 0, 8, 3);
      b_run("coinc", 16'd121, 7, 8'd11, 0, 11, 7);
      b_run("to2", 16'd9, -1, 8'd0, 1, 0, 7);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sqrt_job_sequencer.md
Name: sqrt_job_sequencer

Overview:
- Upstream front-end for the square-root controller/datapath pair.
- Accepts operands over a valid/ready stream, holds the operand stable for the datapath and pulses Start to the controller.
- Waits for Done, captures the datapath result and returns it over an output valid/ready stream.
- Has one pending-operand slot so the next job can be queued while a result is still unconsumed, plus a watchdog timeout.

Parameters:
- WIDTH, 16, operand width in bits
- RES_WIDTH, 8, result width in bits (WIDTH/2)
- TIMEOUT, 64, max cycles in WAIT before abort; legal range 2..1023

Ports:
- clk  in  1  single clock, rising edge
- CLR  in  1  asynchronous active-low reset
- in_valid  in  1  operand offered
- in_ready  out  1  sequencer can take an operand this cycle
- in_data  in  WIDTH  operand
- Start  out  1  one-cycle start pulse to the controller
- Done  in  1  controller completion flag
- dp_operand  out  WIDTH  operand held stable for the datapath
- dp_result  in  RES_WIDTH  datapath root output, valid when Done=1
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  RES_WIDTH  result
- out_err  out  1  qualifies out_data; 1 = timeout abort
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (CLR=0, async), all of these forced to their values:
  - state=IDLE
  - Start=0, out_valid=0, out_err=0
  - out_data=0, dp_operand=0
  - pend_valid=0, pend_data=0
  - wd_cnt=0, busy=0
  - in_ready is combinational and equals 1 in IDLE.
- Reset mid-job drops the job silently; there is no Start glitch.
- States:
  - IDLE: in_ready=1.
    - in_valid&in_ready: dp_operand<=in_data, go to START.
  - START: Start=1 for exactly this one cycle; wd_cnt<=0; go to WAIT.
    - in_ready=0.
  - WAIT: wd_cnt increments each cycle.
    - Done=1: out_data<=dp_result, out_err<=0, go to OUT.
    - Else if wd_cnt==TIMEOUT-1: out_data<=0, out_err<=1, go to OUT.
    - Done has priority over timeout in the same cycle.
    - Done is sampled only in WAIT. In IDLE, START and OUT it is ignored.
  - OUT: out_valid=1; out_data and out_err are held until the handshake.
    - in_ready=!pend_valid. An accepted operand goes to pend_data with pend_valid<=1.
    - out_valid&out_ready with pend_valid=1: dp_operand<=pend_data, pend_valid<=0, go to START. This is a back-to-back job.
    - out_valid&out_ready with pend_valid=0: go to IDLE.
    - Operand accept and result handshake in the same cycle (pend was empty): the new operand goes straight to dp_operand, go to START, pend_valid stays 0.
- dp_operand changes only on the transition into START. It is stable from Start through Done.
- Latency:
  - Operand accepted at cycle t.
  - Start=1 at t+1.
  - Done first seen at cycle d ≥ t+2; out_valid=1 at d+1.
  - Timeout: out_valid at t+2+TIMEOUT.
- The input side never drops or duplicates operands. Results are returned in acceptance order.
- busy=1 in START, WAIT and OUT.

Test Plan:
- Single job: in_data=144; model returns dp_result=12 with Done 10 cycles after Start. Required: Start is exactly 1 cycle; out_valid=1 with out_data=12 and out_err=0 one cycle after Done; returns to IDLE after out_ready.
- Backpressure and queue: send 625 then 81 with out_ready held 0.
  - 81 is accepted into the pending slot and in_ready then drops to 0.
  - On out_ready: out_data=25, then Start for 81 on the next cycle, then out_data=9.
- Timeout: TIMEOUT=8, Done never asserted. Required: out_valid with out_err=1 and out_data=0 at 8 cycles after WAIT entry; next job completes normally.
- Done coincident with the last watchdog cycle (wd_cnt=TIMEOUT-1): result is captured and out_err=0.
- Spurious Done held high in IDLE and OUT: ignored. Done pulsed in the START cycle: ignored; only a Done in WAIT completes.
- Async reset asserted in WAIT and in OUT with pend_valid=1: all outputs read their reset values immediately (in_ready=1); the pending operand is discarded; a fresh job of 16 returns 4.
